neuron_accum: RTL

Parametrised, sequential successor to the fixed 8-input combinational neuron adder. Accepts LANES signed products per beat over BEATS beats, adds a signed bias once, and produces one saturated OUT_W-bit neuron pre-activation per neuron. Optional ReLU is selected at runtime. Sits between the multiplier array and the activation/writeback stage, with valid/ready handshakes on both sides.

---
 rtl/neuron_accum.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/neuron_accum.sv
// neuron_accum
//   Sequential neuron pre-activation adder. Each neuron is BEATS beats of
//   LANES signed products plus one signed bias, taken on the first beat.
//   The total is clamped to OUT_W bits. An optional ReLU, chosen on the
//   first beat, is then applied.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_data   LANES x IN_W signed lanes, lane i at [i*IN_W +: IN_W]
//   bias      signed bias, used only on the first beat of a neuron
//   in_valid  beat valid
//   in_ready  block can accept a beat (low in OUT and while in reset)
//   relu_en   clamp negative results to 0, used only on the first beat
//   out_val   saturated (and optionally rectified) result
//   out_sat   result was clamped to the OUT_W range (before ReLU)
//   out_valid result valid
//   out_ready downstream accepts the result
module neuron_accum #(
    parameter int IN_W  = 8,
    parameter int LANES = 8,
    parameter int BEATS = 2,
    parameter int OUT_W = 12,
    parameter int INT_W = IN_W + $clog2(LANES * BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*IN_W-1:0]   in_data,
    input  logic [IN_W-1:0]         bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    relu_en,
    output logic [OUT_W-1:0]        out_val,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CNT_W = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                    state_reg, state_next;
    logic signed [INT_W-1:0]   acc_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic                      relu_reg;

    logic signed [INT_W-1:0]   lane_ext [LANES];
    logic signed [INT_W-1:0]   bias_ext;
    logic signed [INT_W-1:0]   lane_sum;
    logic signed [INT_W-1:0]   acc_base;
    logic signed [INT_W-1:0]   acc_sum;
    logic [OUT_W-1:0]          sat_val;
    logic                      sat_flag;
    logic [OUT_W-1:0]          res_val;
    logic                      relu_eff;
    logic                      accept;
    logic                      last_beat;

    // Sign-extend every lane to the full internal width before adding so
    // that no partial sum can wrap.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_ext[gi] = INT_W'($signed(in_data[gi*IN_W +: IN_W]));
        end
    endgenerate

    assign bias_ext = INT_W'($signed(bias));

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + lane_ext[i];
        end
    end

    // A first beat starts from the bias. Later beats start from the running
    // total.
    assign acc_base = (state_reg == IDLE) ? bias_ext : acc_reg;
    assign acc_sum  = acc_base + lane_sum;

    assign accept    = in_valid && in_ready;
    assign last_beat = (state_reg == IDLE) ? (BEATS == 1)
                                           : (cnt_reg == CNT_W'(BEATS - 1));

    // Clamp the final total to the OUT_W range. Only needed when the
    // internal width is wider than the output.
    generate
        if (OUT_W < INT_W) begin : g_clamp
            localparam logic signed [INT_W-1:0] SAT_MAX =
                {{(INT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [INT_W-1:0] SAT_MIN =
                {{(INT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            always_comb begin
                sat_val  = acc_sum[OUT_W-1:0];
                sat_flag = 1'b0;
                if (acc_sum > SAT_MAX) begin
                    sat_val  = {1'b0, {(OUT_W-1){1'b1}}};
                    sat_flag = 1'b1;
                end else if (acc_sum < SAT_MIN) begin
                    sat_val  = {1'b1, {(OUT_W-1){1'b0}}};
                    sat_flag = 1'b1;
                end
            end
        end else begin : g_noclamp
            assign sat_val  = OUT_W'(acc_sum);
            assign sat_flag = 1'b0;
        end
    endgenerate

    // With a single beat per neuron, the first beat is also the last one.
    // The latched ReLU choice is not ready yet, so take relu_en directly.
    assign relu_eff = (state_reg == IDLE) ? relu_en : relu_reg;
    assign res_val  = (relu_eff && sat_val[OUT_W-1]) ? '0 : sat_val;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = last_beat ? OUT : ACCUM;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = rst_n && (state_reg != OUT);
        out_valid = (state_reg == OUT);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            cnt_reg  <= '0;
            relu_reg <= 1'b0;
            out_val  <= '0;
            out_sat  <= 1'b0;
        end else if (accept) begin
            acc_reg <= acc_sum;
            if (state_reg == IDLE) begin
                cnt_reg  <= CNT_W'(1);
                relu_reg <= relu_en;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (last_beat) begin
                out_val <= res_val;
                out_sat <= sat_flag;
            end
        end
    end

endmodule
